// File: rtl/multicycle_ctrl_if.sv
// Shared memory port handshake between the multi-cycle controller and memory.
// The controller holds a request until memory acknowledges it.
interface multicycle_ctrl_if;
    logic mem_req_o;
    logic mem_write_o;
    logic i_or_d_o;
    logic mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_write_o,
        output i_or_d_o,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_write_o,
        input  i_or_d_o,
        output mem_ack_i
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port with wait states. Outputs are Moore/Mealy from state and opcode.
module multicycle_ctrl #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    instr_op_i,
    multicycle_ctrl_if.master  mem,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pc_src_o,
    output logic [1:0]         branch_type_o,
    output logic               reg_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               alu_src_o,
    output logic               sign_ext_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               illegal_o,
    output logic               instr_done_o,
    output logic [2:0]         state_o
);

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LUI  = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BGEZ = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_BGT  = OP_W'(6'b000111);
    localparam logic [OP_W-1:0] OP_BNEZ = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b000011);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t state;
    state_t state_nx;

    logic is_r, is_lw, is_sw, is_addi, is_ori, is_lui;
    logic is_br, is_j, is_jal;
    logic [1:0] br_type;

    logic       req, mwr, iord, irw, pcw, pcwc, regw, src, sext, ill, done;
    logic [1:0] pcs, bt, rdst, m2r;
    logic [2:0] aop;

    logic [2:0] alu_aop;
    logic       alu_src_v;
    logic       alu_sext;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= S_FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        is_r    = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_addi = 1'b0;
        is_ori  = 1'b0;
        is_lui  = 1'b0;
        is_br   = 1'b0;
        is_j    = 1'b0;
        is_jal  = 1'b0;
        br_type = 2'b00;
        case (instr_op_i)
            OP_R:    is_r    = 1'b1;
            OP_LW:   is_lw   = 1'b1;
            OP_SW:   is_sw   = 1'b1;
            OP_ADDI: is_addi = 1'b1;
            OP_ORI:  is_ori  = 1'b1;
            OP_LUI:  is_lui  = 1'b1;
            OP_BEQ:  begin is_br = 1'b1; br_type = 2'b00; end
            OP_BGEZ: begin is_br = 1'b1; br_type = 2'b01; end
            OP_BGT:  begin is_br = 1'b1; br_type = 2'b10; end
            OP_BNEZ: begin is_br = 1'b1; br_type = 2'b11; end
            OP_J:    is_j    = 1'b1;
            OP_JAL:  is_jal  = 1'b1;
            default: ;
        endcase
    end

    // ALU setup is shared by EXEC and WB so the result stays stable in WB.
    always_comb begin
        alu_aop   = 3'b000;
        alu_src_v = 1'b0;
        alu_sext  = 1'b0;
        unique case (1'b1)
            is_r: alu_aop = 3'b010;
            is_addi, is_lw, is_sw: begin
                alu_src_v = 1'b1;
                alu_sext  = 1'b1;
            end
            is_ori: begin
                alu_aop   = 3'b011;
                alu_src_v = 1'b1;
            end
            is_lui: begin
                alu_aop   = 3'b100;
                alu_src_v = 1'b1;
            end
            is_br: begin
                alu_aop  = 3'b001;
                alu_sext = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        req  = 1'b0;
        mwr  = 1'b0;
        iord = 1'b0;
        irw  = 1'b0;
        pcw  = 1'b0;
        pcwc = 1'b0;
        pcs  = 2'b00;
        bt   = 2'b00;
        regw = 1'b0;
        rdst = 2'b00;
        m2r  = 2'b00;
        src  = 1'b0;
        sext = 1'b0;
        aop  = 3'b000;
        ill  = 1'b0;
        done = 1'b0;
        case (state)
            S_FETCH: begin
                req = 1'b1;
                if (mem.mem_ack_i) begin
                    irw      = 1'b1;
                    pcw      = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    pcw      = 1'b1;
                    pcs      = 2'b10;
                    done     = 1'b1;
                    state_nx = S_FETCH;
                    if (is_jal) begin
                        regw = 1'b1;
                        rdst = 2'b10;
                        m2r  = 2'b10;
                    end
                end else if (is_r || is_lw || is_sw || is_addi ||
                             is_ori || is_lui || is_br) begin
                    state_nx = S_EXEC;
                end else begin
                    ill      = 1'b1;
                    done     = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_EXEC: begin
                aop  = alu_aop;
                src  = alu_src_v;
                sext = alu_sext;
                if (is_br) begin
                    pcwc     = 1'b1;
                    pcs      = 2'b01;
                    bt       = br_type;
                    done     = 1'b1;
                    state_nx = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_nx = S_MEM;
                end else if (is_r || is_addi || is_ori || is_lui) begin
                    state_nx = S_WB;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            S_MEM: begin
                req  = 1'b1;
                iord = 1'b1;
                mwr  = is_sw;
                if (mem.mem_ack_i) begin
                    if (is_sw) begin
                        done     = 1'b1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                aop      = alu_aop;
                src      = alu_src_v;
                sext     = alu_sext;
                regw     = 1'b1;
                done     = 1'b1;
                rdst     = is_r  ? 2'b01 : 2'b00;
                m2r      = is_lw ? 2'b01 : 2'b00;
                state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    // Reset must silence even the FETCH request, so gate every output.
    assign mem.mem_req_o   = rst_i & req;
    assign mem.mem_write_o = rst_i & mwr;
    assign mem.i_or_d_o    = rst_i & iord;
    assign ir_write_o      = rst_i & irw;
    assign pc_write_o      = rst_i & pcw;
    assign pc_write_cond_o = rst_i & pcwc;
    assign pc_src_o        = rst_i ? pcs  : 2'b00;
    assign branch_type_o   = rst_i ? bt   : 2'b00;
    assign reg_write_o     = rst_i & regw;
    assign reg_dst_o       = rst_i ? rdst : 2'b00;
    assign mem_to_reg_o    = rst_i ? m2r  : 2'b00;
    assign alu_src_o       = rst_i & src;
    assign sign_ext_o      = rst_i & sext;
    assign alu_op_o        = rst_i ? ALUOP_W'(aop) : '0;
    assign illegal_o       = rst_i & ill;
    assign instr_done_o    = rst_i & done;
    assign state_o         = rst_i ? state : 3'd0;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main control unit for the MIPS-subset CPU. It replaces the single-cycle opcode decoder with a registered state machine that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives one shared memory port through a req/ack handshake, so memory may insert any number of wait states. It sits between the instruction register (opcode source) and the datapath muxes, register file, ALU control and PC.

## Interface
- OP_W, 6: opcode width.
- ALUOP_W, 3: width of alu_op_o; must be ≥3.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- instr_op_i  in  OP_W  opcode from instruction register; stable from DECODE until return to FETCH.
- mem_ack_i  in  1  memory completion; sampled only while mem_req_o=1.
- mem_req_o  out  1  memory access request.
- mem_write_o  out  1  store qualifier for mem_req_o.
- i_or_d_o  out  1  memory address select: 0=PC, 1=ALU result register.
- ir_write_o  out  1  load instruction register.
- pc_write_o  out  1  unconditional PC update.
- pc_write_cond_o  out  1  PC update if branch condition is true.
- pc_src_o  out  2  PC source: 00=PC+4, 01=branch target, 10=jump target.
- branch_type_o  out  2  condition select: 00 beq, 01 bgez, 10 bgt, 11 bnez.
- reg_write_o  out  1  register file write.
- reg_dst_o  out  2  destination: 00=rt, 01=rd, 10=$31.
- mem_to_reg_o  out  2  write-back source: 00=ALU, 01=memory data, 10=PC+4.
- alu_src_o  out  1  ALU operand B: 0=rt, 1=extended immediate.
- sign_ext_o  out  1  immediate extension: 1=sign, 0=zero.
- alu_op_o  out  ALUOP_W  000 add, 001 sub, 010 funct-decoded, 011 or, 100 lui. Upper bits are zero.
- illegal_o  out  1  one-cycle pulse on an undecodable opcode.
- instr_done_o  out  1  one-cycle pulse in the last cycle of each instruction.
- state_o  out  3  current state, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 are unreachable; if entered, go to FETCH.
- Every output not listed as asserted for a state is 0.
- FETCH
  - mem_req_o=1, i_or_d_o=0.
  - Hold until mem_ack_i=1.
  - In the ack cycle: ir_write_o=1, pc_write_o=1, pc_src_o=00, next state DECODE.
- DECODE
  - Opcode 000000 (R), 100011 (LW), 101011 (SW), 001000 (ADDI), 001101 (ORI), 001111 (LUI), branches 000100/000001/000111/000101 → EXEC.
  - 000010 (J): pc_write_o=1, pc_src_o=10, instr_done_o=1 → FETCH.
  - 000011 (JAL): as J, plus reg_write_o=1, reg_dst_o=10, mem_to_reg_o=10 → FETCH.
  - Any other opcode: illegal_o=1, instr_done_o=1, no writes → FETCH.
- EXEC
  - R-type: alu_op 010, alu_src 0 → WB.
  - ADDI: alu_op 000, alu_src 1, sign_ext 1 → WB.
  - ORI: alu_op 011, alu_src 1, sign_ext 0 → WB.
  - LUI: alu_op 100, alu_src 1, sign_ext 0 → WB.
  - LW/SW: alu_op 000, alu_src 1, sign_ext 1 → MEM.
  - Branch: alu_op 001, alu_src 0, sign_ext 1, pc_write_cond_o=1, pc_src 01, instr_done_o=1 → FETCH.
  - Branch type: BEQ=00, BGEZ=01, BGT=10, BNEZ=11.
- MEM
  - mem_req_o=1, i_or_d_o=1; mem_write_o=1 for SW.
  - Hold until mem_ack_i.
  - On ack: LW → WB; SW → FETCH with instr_done_o=1.
- WB
  - reg_write_o=1, instr_done_o=1 → FETCH.
  - R-type: reg_dst 01. Immediate ops: reg_dst 00, mem_to_reg 00. LW: reg_dst 00, mem_to_reg 01.
  - alu_src_o, sign_ext_o and alu_op_o keep their EXEC values in WB.

## Timing
- Outputs are combinational from the state register and instr_op_i; mem_ack_i gates the FETCH/MEM transition outputs. The state register is the only storage.
- Reset
  - rst_i=0 forces FETCH asynchronously.
  - While rst_i=0, all outputs are forced to 0, including mem_req_o; state_o=0.
  - First request in the first cycle after release.
  - Reset mid-instruction abandons the instruction; no partial write is issued after reset asserts.
- Cycle counts with zero-wait memory (ack in the same cycle as the request):
  - J/JAL/illegal: 2.
  - Branch: 3.
  - SW, R-type, immediate ops: 4.
  - LW: 5.
  - Each wait cycle adds 1.
- mem_req_o stays high until ack. mem_write_o, i_or_d_o and all other outputs are stable across wait cycles.
- An ack while no request is pending is ignored.
- instr_done_o is high exactly once per instruction. illegal_o coincides with instr_done_o.

## Test plan
- Reset held 3 cycles, released with mem_ack_i=1, R-type opcode:
  - All outputs 0 during reset.
  - Then state sequence 0,1,2,4,0.
  - reg_write_o=1 and reg_dst_o=01 in cycle 4; one instr_done_o pulse.
- LW, 2 wait cycles in both FETCH and MEM:
  - mem_req_o high for 3 cycles in each, i_or_d_o 0 then 1.
  - WB asserts mem_to_reg_o=01; total 9 cycles.
- BGT (000111):
  - EXEC asserts pc_write_cond_o=1, branch_type_o=10, alu_op_o=001, pc_src_o=01.
  - No reg_write_o; next state FETCH.
- JAL (000011):
  - DECODE asserts pc_write_o=1, pc_src_o=10, reg_write_o=1, reg_dst_o=10, mem_to_reg_o=10.
  - 2-cycle instruction.
- Opcode 111111:
  - illegal_o and instr_done_o pulse once in DECODE, no write strobes, returns to FETCH.
- SW with rst_i dropped during MEM wait:
  - mem_req_o and mem_write_o fall to 0 immediately; state_o=0 with no clock edge.
  - After release, FETCH resumes with i_or_d_o=0.
